// File: rtl/alu_pkg.sv
// Shared encodings for the ALU select field and the op sequencer FSM.
// Sel layout: [4:3] shift, [2] unit (1=logic, 0=arith), [1:0] op.
package alu_pkg;

  localparam int SEL_W = 5;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_ROTL = 2'b01;
  localparam logic [1:0] SH_ROTR = 2'b10;
  localparam logic [1:0] SH_ZERO = 2'b11;

  localparam logic UNIT_LOGIC = 1'b1;
  localparam logic UNIT_ARITH = 1'b0;

  localparam logic [1:0] LOGIC_AND = 2'b00;
  localparam logic [1:0] LOGIC_OR  = 2'b01;
  localparam logic [1:0] LOGIC_XOR = 2'b10;
  localparam logic [1:0] LOGIC_NOT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Drives a combinational ALU from registers for cmd_count+1 passes; response valid N cycles after accept.
// Commands are refused (cmd_ready_o low) until the response is taken; the response holds until rsp_ready_i.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  input  logic              cmd_cin_i,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic [CNT_W-1:0]  cmd_count_i,
  output logic [SEL_W-1:0]  alu_sel_o,
  output logic              alu_cin_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_y_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_y_o,
  output logic              rsp_zero_o,
  output logic [CNT_W:0]    rsp_passes_o
);

  localparam int PASS_W = CNT_W + 1;

  seq_state_t        state_q, state_d;
  logic [1:0]        shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic              alu_cin_q, alu_cin_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [DATA_W-1:0] rsp_y_q, rsp_y_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic [PASS_W-1:0] rsp_passes_q, rsp_passes_d;
  logic [PASS_W-1:0] last_pass;

  // Extra bit on the pass counter so cmd_count at its maximum cannot wrap.
  assign last_pass = {1'b0, cnt_q} + PASS_W'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      shift_q      <= SH_NONE;
      cnt_q        <= '0;
      pass_q       <= '0;
      alu_sel_q    <= '0;
      alu_cin_q    <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_y_q      <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_passes_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      pass_q       <= pass_d;
      alu_sel_q    <= alu_sel_d;
      alu_cin_q    <= alu_cin_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_y_q      <= rsp_y_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_passes_q <= rsp_passes_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    pass_d       = pass_q;
    alu_sel_d    = alu_sel_q;
    alu_cin_d    = alu_cin_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_y_d      = rsp_y_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_passes_d = rsp_passes_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          shift_d   = cmd_sel_i[4:3];
          cnt_d     = cmd_count_i;
          alu_sel_d = cmd_sel_i;
          alu_cin_d = cmd_cin_i;
          alu_a_d   = cmd_a_i;
          alu_b_d   = cmd_b_i;
          pass_d    = PASS_W'(1);
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_y_d    = alu_y_i;
        rsp_zero_d = (alu_y_i == '0);
        if (pass_q == last_pass) begin
          rsp_passes_d = pass_q;
          state_d      = S_DONE;
        end else begin
          // Y OR Y is the identity, so only the latched shift field acts on later passes.
          alu_a_d   = alu_y_i;
          alu_b_d   = alu_y_i;
          alu_sel_d = {shift_q, UNIT_LOGIC, LOGIC_OR};
          alu_cin_d = 1'b0;
          pass_d    = pass_q + PASS_W'(1);
        end
      end
      S_DONE: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign rsp_valid_o  = (state_q == S_DONE);
  assign alu_sel_o    = alu_sel_q;
  assign alu_cin_o    = alu_cin_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign rsp_y_o      = rsp_y_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_passes_o = rsp_passes_q;

endmodule
